rst_seq_ctrl: RTL and testbench

- Power-up and recovery sequencer for the board clocking: drives the PLL reset and watches the PLL lock indications.
- Releases per-domain reset requests in a fixed order, with programmable gaps, only after every lock has been stable for a set time.
- Runs on the free-running buffered board clock. Its dom_rst outputs feed the per-domain reset synchronizers.
- Re-sequences on lock loss or an external request; latches a fault after repeated lock timeouts.

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/rst_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// a counter width helper that never returns zero.
package rst_seq_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_e;

   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, cleared to 0 on reset.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/rst_seq_ctrl.sv
// PLL reset / lock-watch sequencer releasing per-domain resets in order,
// with re-sequencing on lock loss or external request and a sticky fault.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int unsigned N_DOM            = 2,
   parameter int unsigned PLL_RST_CYC      = 16,
   parameter int unsigned LOCK_STABLE_CYC  = 256,
   parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
   parameter int unsigned REL_GAP_CYC      = 32,
   parameter int unsigned MAX_RETRY        = 3
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_ext_rst_req,
   input  logic [N_DOM-1:0]                    i_pll_locked,
   output logic                                o_pll_rst,
   output logic [N_DOM-1:0]                    o_dom_rst,
   output logic                                o_seq_done,
   output logic                                o_fault,
   output logic [clog2_min1(MAX_RETRY+1)-1:0]  o_retry_cnt,
   output logic [STATE_W-1:0]                  o_state
);

   localparam int unsigned RST_W = clog2_min1(PLL_RST_CYC);
   localparam int unsigned STB_W = clog2_min1(LOCK_STABLE_CYC);
   localparam int unsigned TO_W  = clog2_min1(LOCK_TIMEOUT_CYC);
   localparam int unsigned GAP_W = clog2_min1(REL_GAP_CYC);
   localparam int unsigned IDX_W = clog2_min1(N_DOM);
   localparam int unsigned RTY_W = clog2_min1(MAX_RETRY + 1);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYC - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REL_GAP_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   logic [N_DOM-1:0] w_locked;
   logic             w_ext;
   logic             w_lk;

   state_e           r_state,     w_state_nxt;
   logic [RST_W-1:0] r_rst_cnt,   w_rst_cnt_nxt;
   logic [STB_W-1:0] r_stb_cnt,   w_stb_cnt_nxt;
   logic [TO_W-1:0]  r_to_cnt,    w_to_cnt_nxt;
   logic [GAP_W-1:0] r_gap_cnt,   w_gap_cnt_nxt;
   logic [IDX_W-1:0] r_idx,       w_idx_nxt;
   logic [RTY_W-1:0] r_retry_cnt, w_retry_nxt;
   logic [N_DOM-1:0] r_dom_rst,   w_dom_nxt;
   logic             r_pll_rst,   w_pll_rst_nxt;
   logic             r_seq_done,  w_seq_done_nxt;
   logic             r_fault,     w_fault_nxt;
   logic [RTY_W-1:0] w_retry_inc;

   sync_2ff #(.WIDTH(N_DOM)) u_sync_lock (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_pll_locked),
      .o_q   (w_locked)
   );

   sync_2ff #(.WIDTH(1)) u_sync_ext (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_ext_rst_req),
      .o_q   (w_ext)
   );

   assign w_lk        = &w_locked;
   assign w_retry_inc = r_retry_cnt + RTY_W'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_rst_cnt_nxt = r_rst_cnt;
      w_stb_cnt_nxt = r_stb_cnt;
      w_to_cnt_nxt  = r_to_cnt;
      w_gap_cnt_nxt = r_gap_cnt;
      w_idx_nxt     = r_idx;
      w_retry_nxt   = r_retry_cnt;
      w_dom_nxt     = r_dom_rst;

      if (w_ext) begin
         w_state_nxt   = PLL_RST;
         w_rst_cnt_nxt = '0;
         w_stb_cnt_nxt = '0;
         w_to_cnt_nxt  = '0;
         w_gap_cnt_nxt = '0;
         w_idx_nxt     = '0;
         w_retry_nxt   = '0;
      end else begin
         unique case (r_state)
            PLL_RST: begin
               if (r_rst_cnt == RST_LAST) begin
                  w_state_nxt   = WAIT_LOCK;
                  w_rst_cnt_nxt = '0;
                  w_to_cnt_nxt  = '0;
               end else begin
                  w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (w_lk) begin
                  w_state_nxt   = STABLE;
                  w_stb_cnt_nxt = '0;
               end else if (r_to_cnt == TO_LAST) begin
                  w_retry_nxt   = w_retry_inc;
                  w_to_cnt_nxt  = '0;
                  w_rst_cnt_nxt = '0;
                  w_state_nxt   = (w_retry_inc == RTY_MAX) ? FAULT : PLL_RST;
               end else begin
                  w_to_cnt_nxt = r_to_cnt + TO_W'(1);
               end
            end
            STABLE: begin
               // Timeout timer deliberately kept so a flapping lock still times out.
               if (!w_lk) begin
                  w_state_nxt = WAIT_LOCK;
               end else if (r_stb_cnt == STB_LAST) begin
                  w_state_nxt   = RELEASE;
                  w_idx_nxt     = '0;
                  w_gap_cnt_nxt = '0;
               end else begin
                  w_stb_cnt_nxt = r_stb_cnt + STB_W'(1);
               end
            end
            RELEASE: begin
               if (!w_lk) begin
                  w_state_nxt   = PLL_RST;
                  w_rst_cnt_nxt = '0;
               end else if (r_gap_cnt == GAP_LAST) begin
                  w_dom_nxt[r_idx] = 1'b0;
                  w_gap_cnt_nxt    = '0;
                  if (r_idx == IDX_LAST) begin
                     w_state_nxt = RUN;
                     w_retry_nxt = '0;
                  end else begin
                     w_idx_nxt = r_idx + IDX_W'(1);
                  end
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
               end
            end
            RUN: begin
               if (!w_lk) begin
                  w_state_nxt   = PLL_RST;
                  w_rst_cnt_nxt = '0;
               end
            end
            FAULT: begin
               w_state_nxt = FAULT;
            end
            default: begin
               w_state_nxt   = PLL_RST;
               w_rst_cnt_nxt = '0;
            end
         endcase
      end

      // Domain resets may only be released while in RELEASE or RUN.
      if (w_state_nxt != RELEASE && w_state_nxt != RUN) begin
         w_dom_nxt = '1;
      end
      w_pll_rst_nxt  = (w_state_nxt == PLL_RST) || (w_state_nxt == FAULT);
      w_seq_done_nxt = (w_state_nxt == RUN);
      w_fault_nxt    = (w_state_nxt == FAULT);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= PLL_RST;
         r_rst_cnt   <= '0;
         r_stb_cnt   <= '0;
         r_to_cnt    <= '0;
         r_gap_cnt   <= '0;
         r_idx       <= '0;
         r_retry_cnt <= '0;
         r_dom_rst   <= '1;
         r_pll_rst   <= 1'b1;
         r_seq_done  <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rst_cnt   <= w_rst_cnt_nxt;
         r_stb_cnt   <= w_stb_cnt_nxt;
         r_to_cnt    <= w_to_cnt_nxt;
         r_gap_cnt   <= w_gap_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_retry_cnt <= w_retry_nxt;
         r_dom_rst   <= w_dom_nxt;
         r_pll_rst   <= w_pll_rst_nxt;
         r_seq_done  <= w_seq_done_nxt;
         r_fault     <= w_fault_nxt;
      end
   end

   assign o_state     = r_state;
   assign o_pll_rst   = r_pll_rst;
   assign o_dom_rst   = r_dom_rst;
   assign o_seq_done  = r_seq_done;
   assign o_fault     = r_fault;
   assign o_retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with short timing parameters; each task
// drives one scenario and checks hand-computed cycle positions.
module tb_rst_seq_ctrl;
   import rst_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ext = 1'b0;
   logic [1:0] locked = 2'b00;
   logic       pll_rst;
   logic [1:0] dom_rst;
   logic       seq_done;
   logic       fault;
   logic [1:0] retry;
   logic [2:0] state;

   int n_cmp = 0;
   int n_err = 0;

   rst_seq_ctrl #(
      .N_DOM            (2),
      .PLL_RST_CYC      (4),
      .LOCK_STABLE_CYC  (8),
      .LOCK_TIMEOUT_CYC (64),
      .REL_GAP_CYC      (4),
      .MAX_RETRY        (2)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_ext_rst_req (ext),
      .i_pll_locked  (locked),
      .o_pll_rst     (pll_rst),
      .o_dom_rst     (dom_rst),
      .o_seq_done    (seq_done),
      .o_fault       (fault),
      .o_retry_cnt   (retry),
      .o_state       (state)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (state !== PLL_RST) begin n_err++; $display("FAIL rst_state got=%0d want=%0d", state, PLL_RST); end
      n_cmp++; if (pll_rst !== 1'b1) begin n_err++; $display("FAIL rst_pll got=%b want=1", pll_rst); end
      n_cmp++; if (dom_rst !== 2'b11) begin n_err++; $display("FAIL rst_dom got=%b want=11", dom_rst); end
      n_cmp++; if (seq_done !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL rst_flags got=%b%b want=00", seq_done, fault); end
      n_cmp++; if (retry !== 2'd0) begin n_err++; $display("FAIL rst_retry got=%0d want=0", retry); end
      tick(3);
      n_cmp++; if (state !== PLL_RST || pll_rst !== 1'b1) begin n_err++; $display("FAIL rst_hold got=%0d/%b want=0/1", state, pll_rst); end
      rst = 1'b0;
   endtask

   task automatic test_nominal;
      tick(3);
      n_cmp++; if (state !== PLL_RST || pll_rst !== 1'b1) begin n_err++; $display("FAIL nom_pllrst got=%0d/%b want=0/1", state, pll_rst); end
      tick(1);
      n_cmp++; if (state !== WAIT_LOCK || pll_rst !== 1'b0) begin n_err++; $display("FAIL nom_wait got=%0d/%b want=1/0", state, pll_rst); end
      tick(6);
      locked = 2'b11;
      tick(2);
      n_cmp++; if (state !== WAIT_LOCK) begin n_err++; $display("FAIL nom_sync got=%0d want=%0d", state, WAIT_LOCK); end
      tick(1);
      n_cmp++; if (state !== STABLE) begin n_err++; $display("FAIL nom_stable got=%0d want=%0d", state, STABLE); end
      tick(7);
      n_cmp++; if (state !== STABLE) begin n_err++; $display("FAIL nom_stable7 got=%0d want=%0d", state, STABLE); end
      tick(1);
      n_cmp++; if (state !== RELEASE || dom_rst !== 2'b11) begin n_err++; $display("FAIL nom_rel got=%0d/%b want=3/11", state, dom_rst); end
      tick(3);
      n_cmp++; if (dom_rst !== 2'b11) begin n_err++; $display("FAIL nom_gap0 got=%b want=11", dom_rst); end
      tick(1);
      n_cmp++; if (dom_rst !== 2'b10 || state !== RELEASE) begin n_err++; $display("FAIL nom_dom0 got=%b/%0d want=10/3", dom_rst, state); end
      tick(3);
      n_cmp++; if (dom_rst !== 2'b10 || seq_done !== 1'b0) begin n_err++; $display("FAIL nom_gap1 got=%b/%b want=10/0", dom_rst, seq_done); end
      tick(1);
      n_cmp++; if (dom_rst !== 2'b00 || seq_done !== 1'b1 || state !== RUN) begin n_err++; $display("FAIL nom_run got=%b/%b/%0d want=00/1/4", dom_rst, seq_done, state); end
      n_cmp++; if (retry !== 2'd0 || pll_rst !== 1'b0) begin n_err++; $display("FAIL nom_run_misc got=%0d/%b want=0/0", retry, pll_rst); end
   endtask

   task automatic test_lock_loss_run;
      locked = 2'b10;
      tick(2);
      n_cmp++; if (state !== RUN || seq_done !== 1'b1) begin n_err++; $display("FAIL loss_early got=%0d/%b want=4/1", state, seq_done); end
      tick(1);
      n_cmp++; if (state !== PLL_RST || dom_rst !== 2'b11 || seq_done !== 1'b0 || pll_rst !== 1'b1) begin
         n_err++; $display("FAIL loss_reset got=%0d/%b/%b/%b want=0/11/0/1", state, dom_rst, seq_done, pll_rst);
      end
      locked = 2'b11;
      tick(4);
      n_cmp++; if (state !== WAIT_LOCK) begin n_err++; $display("FAIL loss_wait got=%0d want=%0d", state, WAIT_LOCK); end
      tick(1);
      n_cmp++; if (state !== STABLE) begin n_err++; $display("FAIL loss_stable got=%0d want=%0d", state, STABLE); end
      tick(8);
      n_cmp++; if (state !== RELEASE) begin n_err++; $display("FAIL loss_rel got=%0d want=%0d", state, RELEASE); end
      tick(8);
      n_cmp++; if (state !== RUN || dom_rst !== 2'b00) begin n_err++; $display("FAIL loss_run got=%0d/%b want=4/00", state, dom_rst); end
   endtask

   task automatic test_flap;
      locked = 2'b00;
      tick(3);
      tick(4);
      n_cmp++; if (state !== WAIT_LOCK) begin n_err++; $display("FAIL flap_wait got=%0d want=%0d", state, WAIT_LOCK); end
      locked = 2'b11;
      tick(3);
      n_cmp++; if (state !== STABLE) begin n_err++; $display("FAIL flap_stable got=%0d want=%0d", state, STABLE); end
      tick(5);
      locked = 2'b01;
      tick(1);
      locked = 2'b11;
      tick(1);
      n_cmp++; if (state !== STABLE) begin n_err++; $display("FAIL flap_pre got=%0d want=%0d", state, STABLE); end
      tick(1);
      n_cmp++; if (state !== WAIT_LOCK) begin n_err++; $display("FAIL flap_drop got=%0d want=%0d", state, WAIT_LOCK); end
      tick(1);
      n_cmp++; if (state !== STABLE) begin n_err++; $display("FAIL flap_restab got=%0d want=%0d", state, STABLE); end
      tick(7);
      n_cmp++; if (state !== STABLE || dom_rst !== 2'b11) begin n_err++; $display("FAIL flap_count got=%0d/%b want=2/11", state, dom_rst); end
      tick(1);
      n_cmp++; if (state !== RELEASE) begin n_err++; $display("FAIL flap_rel got=%0d want=%0d", state, RELEASE); end
      tick(8);
      n_cmp++; if (state !== RUN) begin n_err++; $display("FAIL flap_run got=%0d want=%0d", state, RUN); end
   endtask

   task automatic test_timeout_fault;
      locked = 2'b00;
      tick(3);
      n_cmp++; if (state !== PLL_RST || retry !== 2'd0) begin n_err++; $display("FAIL to_start got=%0d/%0d want=0/0", state, retry); end
      tick(4);
      tick(63);
      n_cmp++; if (state !== WAIT_LOCK || pll_rst !== 1'b0 || retry !== 2'd0) begin
         n_err++; $display("FAIL to_edge got=%0d/%b/%0d want=1/0/0", state, pll_rst, retry);
      end
      tick(1);
      n_cmp++; if (state !== PLL_RST || retry !== 2'd1 || pll_rst !== 1'b1) begin
         n_err++; $display("FAIL to_retry1 got=%0d/%0d/%b want=0/1/1", state, retry, pll_rst);
      end
      tick(3);
      n_cmp++; if (pll_rst !== 1'b1) begin n_err++; $display("FAIL to_pulse got=%b want=1", pll_rst); end
      tick(1);
      n_cmp++; if (state !== WAIT_LOCK || pll_rst !== 1'b0) begin n_err++; $display("FAIL to_wait2 got=%0d/%b want=1/0", state, pll_rst); end
      tick(64);
      n_cmp++; if (state !== FAULT || fault !== 1'b1 || retry !== 2'd2) begin
         n_err++; $display("FAIL to_fault got=%0d/%b/%0d want=5/1/2", state, fault, retry);
      end
      n_cmp++; if (pll_rst !== 1'b1 || dom_rst !== 2'b11 || seq_done !== 1'b0) begin
         n_err++; $display("FAIL to_fault_out got=%b/%b/%b want=1/11/0", pll_rst, dom_rst, seq_done);
      end
      tick(50);
      n_cmp++; if (state !== FAULT || fault !== 1'b1 || pll_rst !== 1'b1 || dom_rst !== 2'b11) begin
         n_err++; $display("FAIL to_sticky got=%0d/%b/%b/%b want=5/1/1/11", state, fault, pll_rst, dom_rst);
      end
   endtask

   task automatic test_ext_req;
      ext = 1'b1;
      tick(2);
      n_cmp++; if (state !== FAULT || fault !== 1'b1) begin n_err++; $display("FAIL ext_sync got=%0d/%b want=5/1", state, fault); end
      tick(1);
      n_cmp++; if (state !== PLL_RST || fault !== 1'b0 || retry !== 2'd0) begin
         n_err++; $display("FAIL ext_take got=%0d/%b/%0d want=0/0/0", state, fault, retry);
      end
      tick(7);
      n_cmp++; if (state !== PLL_RST || pll_rst !== 1'b1) begin n_err++; $display("FAIL ext_hold got=%0d/%b want=0/1", state, pll_rst); end
      ext = 1'b0;
      tick(5);
      n_cmp++; if (state !== PLL_RST || pll_rst !== 1'b1) begin n_err++; $display("FAIL ext_tail got=%0d/%b want=0/1", state, pll_rst); end
      tick(1);
      n_cmp++; if (state !== WAIT_LOCK || pll_rst !== 1'b0) begin n_err++; $display("FAIL ext_wait got=%0d/%b want=1/0", state, pll_rst); end
   endtask

   task automatic test_async_reset;
      locked = 2'b11;
      tick(3);
      n_cmp++; if (state !== STABLE) begin n_err++; $display("FAIL ar_stable got=%0d want=%0d", state, STABLE); end
      tick(8);
      tick(4);
      n_cmp++; if (state !== RELEASE || dom_rst !== 2'b10) begin n_err++; $display("FAIL ar_rel got=%0d/%b want=3/10", state, dom_rst); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (dom_rst !== 2'b11 || pll_rst !== 1'b1 || state !== PLL_RST) begin
         n_err++; $display("FAIL ar_async got=%b/%b/%0d want=11/1/0", dom_rst, pll_rst, state);
      end
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_lock_loss_run();
      test_flap();
      test_timeout_fault();
      test_ext_req();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
